// File: rtl/pwm_code_rx.sv
// pwm_code_rx: pulse-width code receiver with synchroniser, glitch filter,
// bit-order select, stop timeout, classified errors and post-error resync.
module pwm_code_rx #(
  parameter int CODE_WIDTH    = 26,
  parameter int BIT_PERIOD    = 20,
  parameter int MARGIN        = 2,
  parameter int GLITCH_CYCLES = 2,
  parameter bit MSB_FIRST     = 1'b1
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  data_in,
  output logic [CODE_WIDTH-1:0] code_out,
  output logic                  new_code_out,
  output logic                  error_out,
  output logic [1:0]            error_code_out,
  output logic                  busy_out
);
  localparam int Q  = BIT_PERIOD / 4;
  localparam int H  = BIT_PERIOD / 2;
  localparam int CW = $clog2(BIT_PERIOD + MARGIN + 2);
  localparam int IW = CODE_WIDTH > 1 ? $clog2(CODE_WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, SYNC_LO, SYNC_HI, BIT_LO, BIT_HI0, BIT_HI1, STOP, RESYNC} state_t;

  logic r_sync1, r_s, w_f;

  always_ff @(posedge clk_in)
    if (!rst_n_in) {r_sync1, r_s} <= 2'b11;
    else {r_sync1, r_s} <= {data_in, r_sync1};

  generate
    if (GLITCH_CYCLES == 0) begin : g_bypass
      assign w_f = r_s;
    end else begin : g_filt
      localparam int GW = GLITCH_CYCLES > 1 ? $clog2(GLITCH_CYCLES) : 1;
      logic          r_f;
      logic [GW-1:0] r_gcnt;
      logic          w_diff;
      // the newer sample must disagree too, so a GLITCH_CYCLES-wide pulse never flips f
      assign w_diff = (r_s != r_f) && (r_sync1 != r_f);
      always_ff @(posedge clk_in)
        if (!rst_n_in) begin
          r_f    <= 1'b1;
          r_gcnt <= '0;
        end else if (w_diff && r_gcnt == GW'(GLITCH_CYCLES - 1)) begin
          r_f    <= r_s;
          r_gcnt <= '0;
        end else r_gcnt <= w_diff ? r_gcnt + 1'b1 : '0;
      assign w_f = r_f;
    end
  endgenerate

  state_t                r_state, w_nx;
  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [CODE_WIDTH-1:0] r_buf, w_shift;
  logic                  w_err, w_store, w_bit, w_pub, w_clr;
  logic [1:0]            w_ec;

  function automatic logic win(input logic [CW-1:0] c, input int n);
    return int'(c) >= n - MARGIN && int'(c) <= n + MARGIN;
  endfunction

  function automatic logic ovr(input logic [CW-1:0] c, input int n);
    return int'(c) > n + MARGIN;
  endfunction

  always_comb begin
    w_nx    = r_state;
    w_err   = 1'b0;
    w_store = 1'b0;
    w_pub   = 1'b0;
    w_clr   = 1'b0;
    w_bit   = r_state == BIT_HI1;
    w_ec    = (r_state == SYNC_LO || r_state == SYNC_HI) ? 2'd0 : (r_state == STOP) ? 2'd2 : 2'd1;
    case (r_state)
      IDLE: if (!w_f) begin
        w_nx  = SYNC_LO;
        w_clr = 1'b1;
      end
      SYNC_LO: if (w_f ? !win(r_cnt, H) : ovr(r_cnt, H)) w_err = 1'b1;
               else if (w_f) w_nx = SYNC_HI;
      SYNC_HI: if (!w_f ? !win(r_cnt, H) : ovr(r_cnt, H)) w_err = 1'b1;
               else if (!w_f) w_nx = BIT_LO;
      BIT_LO: if (w_f) begin
        if (win(r_cnt, Q)) w_nx = BIT_HI0;
        else if (win(r_cnt, 3 * Q)) w_nx = BIT_HI1;
        else w_err = 1'b1;
      end else if (ovr(r_cnt, 3 * Q)) w_err = 1'b1;
      BIT_HI0: if (!w_f ? !win(r_cnt, 3 * Q) : ovr(r_cnt, 3 * Q)) w_err = 1'b1;
               else if (!w_f) w_store = 1'b1;
      BIT_HI1: if (!w_f ? !win(r_cnt, Q) : ovr(r_cnt, Q)) w_err = 1'b1;
               else if (!w_f) w_store = 1'b1;
      STOP: if (ovr(r_cnt, BIT_PERIOD)) w_err = 1'b1;
            else if (w_f) begin
              w_pub = 1'b1;
              w_nx  = IDLE;
            end
      RESYNC: if (w_f && int'(r_cnt) >= BIT_PERIOD - 1) w_nx = IDLE;
      default: w_nx = IDLE;
    endcase
    if (w_store) w_nx = (r_idx == IW'(CODE_WIDTH - 1)) ? STOP : BIT_LO;
    if (w_err) w_nx = RESYNC;
  end

  assign w_shift = MSB_FIRST ? ((r_buf << 1) | CODE_WIDTH'(w_bit))
                             : ((r_buf >> 1) | (CODE_WIDTH'(w_bit) << (CODE_WIDTH - 1)));

  // in RESYNC the counter tracks consecutive high cycles; elsewhere it times the current segment
  always_ff @(posedge clk_in)
    if (!rst_n_in) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_idx          <= '0;
      r_buf          <= '0;
      code_out       <= '0;
      new_code_out   <= 1'b0;
      error_out      <= 1'b0;
      error_code_out <= 2'd0;
    end else begin
      r_state        <= w_nx;
      r_cnt          <= (w_nx != r_state) ? CW'(1) : (r_state == RESYNC && !w_f) ? '0 : (&r_cnt) ? r_cnt : r_cnt + 1'b1;
      r_idx          <= w_clr ? '0 : w_store ? r_idx + 1'b1 : r_idx;
      r_buf          <= w_clr ? '0 : w_store ? w_shift : r_buf;
      code_out       <= w_pub ? r_buf : code_out;
      new_code_out   <= w_pub;
      error_out      <= w_err;
      error_code_out <= w_err ? w_ec : error_code_out;
    end

  assign busy_out = r_state != IDLE;
endmodule

// File: tb/tb_pwm_code_rx.sv
// tb_pwm_code_rx: directed frames with a scoreboard of expected publishes/errors,
// checked by an independent monitor on new_code_out / error_out.
module tb_pwm_code_rx;
  logic       clk = 1'b0, rst_n = 1'b0, data = 1'b1;
  logic [7:0] code, code_lsb;
  logic       new_code, err, busy, new_lsb, err_lsb, busy_lsb;
  logic [1:0] ec, ec_lsb;
  int         total = 0, bad = 0, cyc = 0, rise_cyc = 0;
  logic [7:0] last_code = 8'h00;

  typedef struct packed {logic is_err; logic [1:0] ec; logic [7:0] code;} exp_t;
  exp_t q[$];

  pwm_code_rx #(.CODE_WIDTH(8), .BIT_PERIOD(20), .MARGIN(2), .GLITCH_CYCLES(2), .MSB_FIRST(1'b1)) u_dut (
    .clk_in(clk), .rst_n_in(rst_n), .data_in(data), .code_out(code), .new_code_out(new_code),
    .error_out(err), .error_code_out(ec), .busy_out(busy));

  pwm_code_rx #(.CODE_WIDTH(8), .BIT_PERIOD(20), .MARGIN(2), .GLITCH_CYCLES(2), .MSB_FIRST(1'b0)) u_lsb (
    .clk_in(clk), .rst_n_in(rst_n), .data_in(data), .code_out(code_lsb), .new_code_out(new_lsb),
    .error_out(err_lsb), .error_code_out(ec_lsb), .busy_out(busy_lsb));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic line(input logic v, input int n);
    data = v;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // bits go out first-bit-first from v[7]; gl>0 puts a gl-cycle low inside the first bit's 15-cycle high
  task automatic frame(input logic [7:0] v, input int sl, input int sh, input int stp, input int gl, input int idle);
    line(1'b0, sl);
    line(1'b1, sh);
    for (int i = 7; i >= 0; i--) begin
      line(1'b0, v[i] ? 15 : 5);
      if (gl > 0 && i == 7) begin
        line(1'b1, 6);
        line(1'b0, gl);
        line(1'b1, 9 - gl);
      end else line(1'b1, v[i] ? 5 : 15);
    end
    line(1'b0, stp);
    rise_cyc = cyc;
    line(1'b1, idle);
  endtask

  task automatic expect_code(input logic [7:0] c);
    q.push_back({1'b0, 2'd0, c});
  endtask

  task automatic expect_err(input logic [1:0] e);
    q.push_back({1'b1, e, 8'h00});
  endtask

  always @(negedge clk)
    if (rst_n && (new_code || err)) begin
      exp_t e;
      chk("excl", int'(new_code & err), 0);
      chk("sb_pending", int'(q.size() != 0), 1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("kind", int'(err), int'(e.is_err));
        if (new_code) begin
          chk("code", int'(code), int'(e.code));
          chk("latency", cyc - rise_cyc, 5);
          last_code = e.code;
        end else begin
          chk("err_code", int'(ec), int'(e.ec));
          chk("code_hold", int'(code), int'(last_code));
        end
      end
    end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_code", int'(code), 0);
    chk("rst_new", int'(new_code), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ec", int'(ec), 0);
    chk("rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    line(1'b1, 30);
    expect_code(8'hA5); frame(8'hA5, 10, 10, 10, 0, 30);
    chk("lsb_a5", int'(code_lsb), 'hA5);
    expect_code(8'h01); frame(8'h01, 10, 10, 10, 0, 30);
    chk("lsb_order", int'(code_lsb), 'h80);
    expect_code(8'h3C); frame(8'h3C, 8, 12, 10, 0, 30);
    expect_code(8'hC3); frame(8'hC3, 12, 8, 10, 0, 30);
    expect_err(2'd1);
    line(1'b0, 10); line(1'b1, 10); line(1'b0, 11); line(1'b1, 40);
    expect_code(8'h66); frame(8'h66, 10, 10, 10, 0, 30);
    expect_err(2'd0);
    line(1'b0, 13); line(1'b1, 40);
    expect_code(8'h99); frame(8'h99, 10, 10, 10, 0, 30);
    expect_code(8'h5A); frame(8'h5A, 10, 10, 10, 2, 30);
    expect_err(2'd1); frame(8'h5A, 10, 10, 10, 4, 40);
    expect_code(8'h24); frame(8'h24, 10, 10, 10, 0, 30);
    expect_err(2'd2); frame(8'hFF, 10, 10, 30, 0, 0);
    line(1'b1, 18);
    chk("resync_busy", int'(busy), 1);
    line(1'b1, 8);
    chk("resync_idle", int'(busy), 0);
    line(1'b1, 10);
    line(1'b0, 10); line(1'b1, 10); line(1'b0, 5); line(1'b1, 15); line(1'b0, 5); line(1'b1, 7);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_code", int'(code), 0);
    chk("mid_rst_new", int'(new_code), 0);
    chk("mid_rst_err", int'(err), 0);
    chk("mid_rst_ec", int'(ec), 0);
    chk("mid_rst_busy", int'(busy), 0);
    rst_n = 1'b1;
    last_code = 8'h00;
    expect_err(2'd0);
    line(1'b1, 7);
    for (int i = 0; i < 5; i++) begin
      line(1'b0, 5);
      line(1'b1, 15);
    end
    line(1'b0, 10); line(1'b1, 40);
    expect_code(8'h96); frame(8'h96, 10, 10, 10, 0, 30);
    line(1'b1, 20);
    chk("sb_drain", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
